// File: rtl/led_cmd_ctrl_pkg.sv
// Shared command codes, frame widths, chip-select levels and FSM state type
// for the LED command controller.
package led_cmd_ctrl_pkg;

    localparam int CMD_BITS           = 8;
    localparam int ADDR_BITS          = 8;
    localparam int PAYLOAD_BITS       = 8;
    localparam int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;

    localparam logic [CMD_BITS-1:0] CMD_NOP   = 8'h00;
    localparam logic [CMD_BITS-1:0] CMD_WRITE = 8'h01;
    localparam logic [CMD_BITS-1:0] CMD_READ  = 8'h02;
    localparam logic [CMD_BITS-1:0] CMD_ERR   = 8'hEE;

    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;

    // PWM resolution: duty is a percentage, so one period is 100 steps
    localparam int PWM_STEPS = 100;
    localparam logic [PAYLOAD_BITS-1:0] DUTY_MAX = PAYLOAD_BITS'(PWM_STEPS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WRITE,
        ST_LOAD_TX,
        ST_TX_WAIT
    } state_e;

    // Brightness above 100 % saturates at full on
    function automatic logic [PAYLOAD_BITS-1:0] clamp_duty(input logic [PAYLOAD_BITS-1:0] p);
        return (p > DUTY_MAX) ? DUTY_MAX : p;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// Multi-channel PWM: shared prescaler and 0..99 step counter, one shadowed
// duty comparator per channel. Shadows reload only at the period wrap so a
// duty change never chops a period in half.
module led_pwm
    import led_cmd_ctrl_pkg::*;
#(
    parameter int NUM_LEDS     = 4,
    parameter int PWM_PRESCALE = 1250
) (
    input  logic                                   sysclk,
    input  logic                                   rst,
    input  logic [NUM_LEDS-1:0][PAYLOAD_BITS-1:0]  duty,
    output logic [NUM_LEDS-1:0]                    o_led
);

    localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_PRESCALE - 1);
    localparam logic [6:0]    STEP_LAST  = 7'(PWM_STEPS - 1);

    logic [PW-1:0]                        presc_q, presc_d;
    logic [6:0]                           step_q, step_d;
    logic [NUM_LEDS-1:0][PAYLOAD_BITS-1:0] act_q, act_d;
    logic [NUM_LEDS-1:0]                  led_q, led_d;
    logic                                 presc_wrap, step_wrap;

    assign presc_wrap = (presc_q == PRESC_LAST);
    assign step_wrap  = presc_wrap && (step_q == STEP_LAST);

    // Prescaler and step counter advance
    always_comb begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        step_d  = step_q;
        if (presc_wrap) step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
    end

    // Per-channel shadow reload and registered comparator (glitch-free pin)
    for (genvar n = 0; n < NUM_LEDS; n++) begin : g_ch
        assign act_d[n] = step_wrap ? duty[n] : act_q[n];
        assign led_d[n] = PAYLOAD_BITS'(step_q) < act_q[n];
    end

    // Counter, shadow and output registers
    always_ff @(posedge sysclk) begin
        if (rst) begin
            presc_q <= '0;
            step_q  <= '0;
            act_q   <= '0;
            led_q   <= '0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            act_q   <= act_d;
            led_q   <= led_d;
        end
    end

    assign o_led = led_q;

endmodule

// File: rtl/led_cmd_ctrl.sv
// LED command controller: takes decoded SPI frames, updates per-LED duty
// registers, answers reads/errors with a response frame held until the
// master deasserts cs, and drives the LEDs through led_pwm.
module led_cmd_ctrl
    import led_cmd_ctrl_pkg::*;
#(
    parameter int NUM_LEDS     = 4,
    parameter int PWM_PRESCALE = 1250
) (
    input  logic                          sysclk,
    input  logic                          rst,
    input  logic                          cs,
    input  logic                          rx_dv,
    input  logic [CMD_BITS-1:0]           i_cmd,
    input  logic [ADDR_BITS-1:0]          i_addr,
    input  logic [PAYLOAD_BITS-1:0]       i_payload,
    output logic                          slv_tx_enb,
    output logic [MASTER_FRAME_WIDTH-1:0] o_slv_frame,
    output logic [NUM_LEDS-1:0]           o_led,
    output logic                          o_err
);

    localparam logic [ADDR_BITS-1:0] ADDR_LIMIT = ADDR_BITS'(NUM_LEDS);

    state_e                                state_q, state_d;
    logic [CMD_BITS-1:0]                   cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]                  addr_q, addr_d;
    logic [PAYLOAD_BITS-1:0]               pay_q, pay_d;
    logic [NUM_LEDS-1:0][PAYLOAD_BITS-1:0] duty_q, duty_d;
    logic                                  tx_enb_q, tx_enb_d;
    logic [MASTER_FRAME_WIDTH-1:0]         frame_q, frame_d;
    logic                                  err_q, err_d;
    // [0] metastable, [1] synchronized, [2] previous for edge detect
    logic [2:0]                            cs_pipe_q, cs_pipe_d;

    logic                    addr_ok, is_wr, is_rd, is_nop, cs_rise;
    logic [PAYLOAD_BITS-1:0] rd_duty;

    assign addr_ok = (addr_q < ADDR_LIMIT);
    assign is_wr   = (cmd_q == CMD_WRITE) && addr_ok;
    assign is_rd   = (cmd_q == CMD_READ) && addr_ok;
    assign is_nop  = (cmd_q == CMD_NOP);
    assign cs_rise = cs_pipe_q[1] && !cs_pipe_q[2];
    assign cs_pipe_d = {cs_pipe_q[1:0], cs};

    // Duty readback mux; loop avoids indexing past NUM_LEDS on bad addresses
    always_comb begin
        rd_duty = '0;
        for (int n = 0; n < NUM_LEDS; n++)
            if (addr_q == ADDR_BITS'(n)) rd_duty = duty_q[n];
    end

    // All registers; rst overrides everything including a pending rx_dv
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            pay_q     <= '0;
            duty_q    <= '0;
            tx_enb_q  <= 1'b0;
            frame_q   <= '0;
            err_q     <= 1'b0;
            cs_pipe_q <= {3{CS_DEASSERT}};
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            pay_q     <= pay_d;
            duty_q    <= duty_d;
            tx_enb_q  <= tx_enb_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
            cs_pipe_q <= cs_pipe_d;
        end
    end

    // Next-state logic; rx_dv outside IDLE is simply ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (rx_dv) state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_wr)       state_d = ST_WRITE;
                else if (is_nop) state_d = ST_IDLE;
                else             state_d = ST_LOAD_TX;  // valid read or error
            end
            ST_WRITE:   state_d = ST_IDLE;
            ST_LOAD_TX: state_d = ST_TX_WAIT;
            ST_TX_WAIT: if (cs_rise) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath / output updates per state
    always_comb begin
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        pay_d    = pay_q;
        duty_d   = duty_q;
        tx_enb_d = tx_enb_q;
        frame_d  = frame_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_dv) begin
                    cmd_d  = i_cmd;
                    addr_d = i_addr;
                    pay_d  = i_payload;
                end
            end
            ST_DECODE:  err_d = !(is_wr || is_rd || is_nop);
            ST_WRITE: begin
                for (int n = 0; n < NUM_LEDS; n++)
                    if (addr_q == ADDR_BITS'(n)) duty_d[n] = clamp_duty(pay_q);
            end
            ST_LOAD_TX: begin
                tx_enb_d = 1'b1;
                frame_d  = is_rd ? {CMD_READ, addr_q, rd_duty}
                                 : {CMD_ERR, addr_q, cmd_q};
            end
            ST_TX_WAIT: begin
                if (cs_rise) begin
                    tx_enb_d = 1'b0;
                    frame_d  = '0;
                end
            end
            default: ;
        endcase
    end

    led_pwm #(
        .NUM_LEDS     (NUM_LEDS),
        .PWM_PRESCALE (PWM_PRESCALE)
    ) u_pwm (
        .sysclk (sysclk),
        .rst    (rst),
        .duty   (duty_q),
        .o_led  (o_led)
    );

    assign slv_tx_enb  = tx_enb_q;
    assign o_slv_frame = frame_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Bench for led_cmd_ctrl: scenario tasks with a response-frame scoreboard
// and a duty model; small prescaler keeps PWM periods short.
module tb_led_cmd_ctrl;
    import led_cmd_ctrl_pkg::*;

    localparam int NL = 4;
    localparam int PS = 4;
    localparam int PERIOD = PS * PWM_STEPS;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1, cs = 1'b1, rx_dv = 1'b0;
    logic [7:0]  i_cmd = '0, i_addr = '0, i_payload = '0;
    logic        slv_tx_enb;
    logic [23:0] o_slv_frame;
    logic [NL-1:0] o_led;
    logic        o_err;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];
    int duty_m[NL];

    led_cmd_ctrl #(.NUM_LEDS(NL), .PWM_PRESCALE(PS)) dut (
        .sysclk(sysclk), .rst(rst), .cs(cs), .rx_dv(rx_dv),
        .i_cmd(i_cmd), .i_addr(i_addr), .i_payload(i_payload),
        .slv_tx_enb(slv_tx_enb), .o_slv_frame(o_slv_frame),
        .o_led(o_led), .o_err(o_err));

    always #4 sysclk = ~sysclk;

    function automatic int clampm(input int p);
        return (p > 100) ? 100 : p;
    endfunction

    function automatic logic [23:0] exp_frame(input logic [7:0] c, input logic [7:0] a);
        if (c == 8'h02 && a < NL) return {8'h02, a, 8'(duty_m[a])};
        return {8'hEE, a, c};
    endfunction

    task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
        @(negedge sysclk);
        rx_dv = 1'b1; i_cmd = c; i_addr = a; i_payload = p;
        @(negedge sysclk);
        rx_dv = 1'b0;
    endtask

    task automatic check_duties(input string name);
        for (int n = 0; n < NL; n++) begin
            checks++;
            if (dut.duty_q[n] !== 8'(duty_m[n])) begin
                errors++;
                $display("FAIL %s duty[%0d]: got %0d want %0d", name, n, dut.duty_q[n], duty_m[n]);
            end
        end
    endtask

    // Issue a read/error command, match its response against the scoreboard,
    // verify it holds, then release cs and time the clear.
    task automatic transact(input logic [7:0] c, input logic [7:0] a, input bit drop);
        logic [23:0] f;
        int t;
        cs = CS_ASSERT;
        repeat (4) @(negedge sysclk);
        send(c, a, 8'h00);
        exp_q.push_back(exp_frame(c, a));
        t = 0;
        while (slv_tx_enb !== 1'b1 && t < 10) begin @(negedge sysclk); t++; end
        checks++;
        if (slv_tx_enb !== 1'b1) begin
            errors++;
            $display("FAIL tx_enb_timeout: got %b want 1", slv_tx_enb);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got frame %h want none", o_slv_frame);
            f = o_slv_frame;
        end else begin
            f = exp_q.pop_front();
            if (o_slv_frame !== f) begin
                errors++;
                $display("FAIL frame: got %h want %h", o_slv_frame, f);
            end
        end
        if (drop) send(8'h01, 8'h01, 8'd77);
        repeat (5) begin
            @(negedge sysclk);
            checks++;
            if (slv_tx_enb !== 1'b1 || o_slv_frame !== f) begin
                errors++;
                $display("FAIL hold: got enb=%b frame=%h want enb=1 frame=%h", slv_tx_enb, o_slv_frame, f);
            end
        end
        cs = CS_DEASSERT;
        t = 0;
        while (slv_tx_enb === 1'b1 && t < 10) begin @(negedge sysclk); t++; end
        checks++;
        if (t != 3 || o_slv_frame !== 24'h0) begin
            errors++;
            $display("FAIL cs_release: got %0d cycles frame=%h want 3 cycles frame=000000", t, o_slv_frame);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = CS_DEASSERT; rx_dv = 1'b0;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        for (int n = 0; n < NL; n++) duty_m[n] = 0;
        checks++;
        if (slv_tx_enb !== 1'b0 || o_slv_frame !== 24'h0 || o_led !== '0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got enb=%b frame=%h led=%b err=%b want 0", slv_tx_enb, o_slv_frame, o_led, o_err);
        end
        check_duties("reset");
    endtask

    task automatic test_write();
        send(8'h01, 8'd2, 8'd50);
        @(negedge sysclk);
        checks++;
        if (dut.duty_q[2] !== 8'd0) begin
            errors++;
            $display("FAIL write_early: got %0d want 0", dut.duty_q[2]);
        end
        @(negedge sysclk);
        duty_m[2] = 50;
        checks++;
        if (dut.duty_q[2] !== 8'd50) begin
            errors++;
            $display("FAIL write_latency: got %0d want 50", dut.duty_q[2]);
        end
    endtask

    task automatic test_clamp();
        int a_t[4] = '{0, 1, 3, 1};
        int p_t[4] = '{200, 101, 100, 0};
        for (int i = 0; i < 4; i++) begin
            send(8'h01, 8'(a_t[i]), 8'(p_t[i]));
            repeat (2) @(negedge sysclk);
            duty_m[a_t[i]] = clampm(p_t[i]);
        end
        check_duties("clamp");
    endtask

    task automatic test_read();
        transact(8'h02, 8'd2, 1'b0);
    endtask

    task automatic test_error();
        transact(8'h01, 8'd7, 1'b0);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b want 1", o_err);
        end
        check_duties("err_nochange");
        send(8'h00, 8'd0, 8'd0);
        @(negedge sysclk);
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL nop_clears_err: got %b want 0", o_err);
        end
        transact(8'h05, 8'd1, 1'b0);
        transact(8'h02, 8'd4, 1'b0);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL err_bad_read: got %b want 1", o_err);
        end
    endtask

    task automatic test_drop();
        transact(8'h02, 8'd0, 1'b1);
        repeat (3) @(negedge sysclk);
        check_duties("drop");
    endtask

    task automatic test_pwm();
        int cnt[NL];
        repeat (2 * PERIOD) @(negedge sysclk);
        for (int n = 0; n < NL; n++) cnt[n] = 0;
        repeat (PERIOD) begin
            @(negedge sysclk);
            for (int n = 0; n < NL; n++) if (o_led[n]) cnt[n]++;
        end
        for (int n = 0; n < NL; n++) begin
            checks++;
            if (cnt[n] != duty_m[n] * PS) begin
                errors++;
                $display("FAIL pwm_high[%0d]: got %0d want %0d", n, cnt[n], duty_m[n] * PS);
            end
        end
    endtask

    // Duty 50 -> 80 written mid-period must only show in the following period
    task automatic test_glitch_free();
        int t, c1, c2;
        logic prev;
        t = 0;
        prev = 1'b1;
        @(negedge sysclk);
        while (!(o_led[2] && !prev) && t < 3 * PERIOD) begin
            prev = o_led[2];
            @(negedge sysclk);
            t++;
        end
        checks++;
        if (!(o_led[2] && !prev)) begin
            errors++;
            $display("FAIL pwm_rise_timeout: got led2=%b want rising edge", o_led[2]);
            return;
        end
        c1 = 0;
        fork
            begin
                for (int i = 0; i < PERIOD; i++) begin
                    if (o_led[2]) c1++;
                    @(negedge sysclk);
                end
            end
            begin
                repeat (100) @(negedge sysclk);
                send(8'h01, 8'd2, 8'd80);
            end
        join
        c2 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (o_led[2]) c2++;
            @(negedge sysclk);
        end
        duty_m[2] = 80;
        checks++;
        if (c1 != 50 * PS || c2 != 80 * PS) begin
            errors++;
            $display("FAIL glitch_free: got %0d/%0d want %0d/%0d", c1, c2, 50 * PS, 80 * PS);
        end
    endtask

    task automatic test_reset_mid_tx();
        int t;
        cs = CS_ASSERT;
        repeat (4) @(negedge sysclk);
        send(8'h02, 8'd2, 8'd0);
        t = 0;
        while (slv_tx_enb !== 1'b1 && t < 10) begin @(negedge sysclk); t++; end
        checks++;
        if (slv_tx_enb !== 1'b1 || o_slv_frame !== {8'h02, 8'h02, 8'(duty_m[2])}) begin
            errors++;
            $display("FAIL mid_tx_setup: got enb=%b frame=%h want 1 %h", slv_tx_enb, o_slv_frame, {8'h02, 8'h02, 8'(duty_m[2])});
        end
        repeat (2) @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        for (int n = 0; n < NL; n++) duty_m[n] = 0;
        checks++;
        if (slv_tx_enb !== 1'b0 || o_slv_frame !== 24'h0 || o_led !== '0) begin
            errors++;
            $display("FAIL reset_mid_tx: got enb=%b frame=%h led=%b want 0", slv_tx_enb, o_slv_frame, o_led);
        end
        check_duties("reset_mid_tx");
        cs = CS_DEASSERT;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic test_rst_priority();
        @(negedge sysclk);
        rst = 1'b1; rx_dv = 1'b1; i_cmd = 8'h01; i_addr = 8'd0; i_payload = 8'd60;
        @(negedge sysclk);
        rst = 1'b0; rx_dv = 1'b0;
        repeat (4) @(negedge sysclk);
        check_duties("rst_priority");
    endtask

    task automatic test_back_to_back();
        send(8'h01, 8'd3, 8'd33);
        repeat (2) @(negedge sysclk);
        duty_m[3] = 33;
        transact(8'h02, 8'd3, 1'b0);
        transact(8'h02, 8'd2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_clamp();
        test_read();
        test_error();
        test_drop();
        test_pwm();
        test_glitch_free();
        test_reset_mid_tx();
        test_rst_priority();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
